// File: rtl/wb_sevenseg_if.sv
// Wishbone slave bus bundle for the seven-segment display controller.
interface wb_sevenseg_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_sevenseg.sv
// Wishbone-mapped 4-digit seven-segment driver with autonomous scan and
// per-digit PWM dimming. All pin outputs are registered.
module wb_sevenseg #(
    parameter int clk_freq = 50000000,
    parameter int scan_hz  = 1000
) (
    input  logic         clk,
    input  logic         reset,
    wb_sevenseg_if.slave bus,
    output logic [6:0]   seg,
    output logic         dp,
    output logic [3:0]   an
);
    localparam int DIV = clk_freq / (scan_hz * 16);
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    // register file
    logic        ctrl_en, ctrl_raw;
    logic [3:0]  blank, dp_on, bright;
    logic [15:0] value;
    logic [27:0] raw;

    // scan state
    logic [DW-1:0] div_cnt;
    logic [3:0]    tick;
    logic [1:0]    digit;
    logic          toggle;

    logic        req;
    logic [31:0] rd_data;
    logic        lit;
    logic [3:0]  nib;
    logic [6:0]  hex_seg, raw_seg;
    logic [6:0]  seg_next;
    logic        dp_next;
    logic [3:0]  an_next;

    // Address/data bits outside the decoded fields are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.wb_adr_i[31:5], bus.wb_adr_i[1:0], bus.wb_dat_i[31:28],
                           bus.wb_dat_i[3:2]};

    // A new access is one not already being acknowledged; this gives the
    // every-other-cycle ack pattern under a continuously held strobe.
    assign req = bus.wb_stb_i & bus.wb_cyc_i & ~bus.wb_ack_o;

    // Read mux; unmapped slots and reserved bits return zero.
    always_comb begin
        rd_data = '0;
        case (bus.wb_adr_i[4:2])
            3'd0: rd_data = {20'd0, dp_on, blank, 2'b00, ctrl_raw, ctrl_en};
            3'd1: rd_data = {16'd0, value};
            3'd2: rd_data = {4'd0, raw};
            3'd3: rd_data = {28'd0, bright};
            3'd4: rd_data = {23'd0, toggle, 6'd0, digit};
            default: rd_data = '0;
        endcase
    end

    // Bus handshake, registered read data and byte-lane register writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_ack_o <= 1'b0;
            bus.wb_dat_o <= '0;
            ctrl_en      <= 1'b0;
            ctrl_raw     <= 1'b0;
            blank        <= '0;
            dp_on        <= '0;
            value        <= '0;
            raw          <= '0;
            bright       <= 4'hF;
        end else begin
            bus.wb_ack_o <= req;
            bus.wb_dat_o <= req ? rd_data : '0;
            if (req && bus.wb_we_i) begin
                case (bus.wb_adr_i[4:2])
                    3'd0: begin
                        if (bus.wb_sel_i[0]) begin
                            ctrl_en  <= bus.wb_dat_i[0];
                            ctrl_raw <= bus.wb_dat_i[1];
                            blank    <= bus.wb_dat_i[7:4];
                        end
                        if (bus.wb_sel_i[1]) dp_on <= bus.wb_dat_i[11:8];
                    end
                    3'd1: begin
                        if (bus.wb_sel_i[0]) value[7:0]  <= bus.wb_dat_i[7:0];
                        if (bus.wb_sel_i[1]) value[15:8] <= bus.wb_dat_i[15:8];
                    end
                    3'd2: begin
                        if (bus.wb_sel_i[0]) raw[7:0]   <= bus.wb_dat_i[7:0];
                        if (bus.wb_sel_i[1]) raw[15:8]  <= bus.wb_dat_i[15:8];
                        if (bus.wb_sel_i[2]) raw[23:16] <= bus.wb_dat_i[23:16];
                        if (bus.wb_sel_i[3]) raw[27:24] <= bus.wb_dat_i[27:24];
                    end
                    3'd3: if (bus.wb_sel_i[0]) bright <= bus.wb_dat_i[3:0];
                    default: ;
                endcase
            end
        end
    end

    // Free-running scan: prescaler -> 16 PWM ticks per slot -> 4 digit slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= '0;
            digit   <= '0;
            toggle  <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick    <= tick + 4'd1;
            if (tick == 4'hF) begin
                digit <= digit + 2'd1;
                if (digit == 2'd3) toggle <= ~toggle;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Next pin values; tick 15 is always dark so adjacent digits never ghost.
    always_comb begin
        lit     = ctrl_en & ~blank[digit] & (tick <= bright) & (tick != 4'hF);
        nib     = value[4*digit +: 4];
        raw_seg = ~raw[7*digit +: 7];
        case (nib)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        an_next  = 4'hF;
        if (lit) begin
            seg_next = ctrl_raw ? raw_seg : hex_seg;
            dp_next  = ~dp_on[digit];
            an_next  = ~(4'b0001 << digit);
        end
    end

    // Pin registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= 4'hF;
        end else begin
            seg <= seg_next;
            dp  <= dp_next;
            an  <= an_next;
        end
    end
endmodule

// File: tb/tb_wb_sevenseg.sv
// Directed bench for wb_sevenseg at clk_freq=1600, scan_hz=10 (DIV=10,
// 160-cycle slot, 640-cycle frame).
module tb_wb_sevenseg;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    wb_sevenseg_if bus();

    wb_sevenseg #(.clk_freq(1600), .scan_hz(10)) dut (
        .clk(clk), .reset(reset), .bus(bus), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // per-frame observations, indexed by digit
    int         cnt[4];
    logic [6:0] segv[4];
    logic       dpv[4];
    int         incons;
    int         dark_bad;
    int         bad_an;

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk); #1;
        bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_sel_i = s; bus.wb_we_i = 1'b1;
        bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (bus.wb_ack_o !== 1'b1 && n < 8);
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
        n_cmp++;
        if (bus.wb_ack_o !== 1'b1) begin
            n_bad++; $display("FAIL wr_ack adr=%h got=%b want=1", a, bus.wb_ack_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.wb_ack_o !== 1'b0) begin
            n_bad++; $display("FAIL wr_ack_len adr=%h got=%b want=0", a, bus.wb_ack_o);
        end
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        bus.wb_adr_i = a; bus.wb_sel_i = 4'hF; bus.wb_we_i = 1'b0;
        bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (bus.wb_ack_o !== 1'b1 && n < 8);
        d = bus.wb_dat_o;
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        n_cmp++;
        if (bus.wb_ack_o !== 1'b1) begin
            n_bad++; $display("FAIL rd_ack adr=%h got=%b want=1", a, bus.wb_ack_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
            n_bad++; $display("FAIL rd_ack_len adr=%h ack=%b dat=%h want 0/0", a, bus.wb_ack_o, bus.wb_dat_o);
        end
    endtask

    // Observe one full frame and summarise per-digit on-time and pin values.
    task automatic scan_frame();
        int d;
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; segv[i] = 7'h7F; dpv[i] = 1'b1; end
        incons = 0; dark_bad = 0; bad_an = 0;
        for (int c = 0; c < 640; c++) begin
            @(posedge clk); #1;
            d = -1;
            case (an)
                4'hE: d = 0;
                4'hD: d = 1;
                4'hB: d = 2;
                4'h7: d = 3;
                4'hF: if (seg !== 7'h7F || dp !== 1'b1) dark_bad++;
                default: bad_an++;
            endcase
            if (d >= 0) begin
                if (cnt[d] == 0) begin segv[d] = seg; dpv[d] = dp; end
                else if (segv[d] !== seg || dpv[d] !== dp) incons++;
                cnt[d]++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_bad++; $display("FAIL reset_pins an=%h seg=%h dp=%b want F/7F/1", an, seg, dp);
        end
        n_cmp++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
            n_bad++; $display("FAIL reset_bus ack=%b dat=%h want 0/0", bus.wb_ack_o, bus.wb_dat_o);
        end
        wb_read(32'h7004_0000, r);
        n_cmp++;
        if (r !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl got=%h want=0", r); end
        wb_read(32'h7004_000C, r);
        n_cmp++;
        if (r !== 32'hF) begin n_bad++; $display("FAIL reset_bright got=%h want=F", r); end
        wb_read(32'h7004_001C, r);
        n_cmp++;
        if (r !== 32'h0) begin n_bad++; $display("FAIL unmapped_rd got=%h want=0", r); end
    endtask

    task automatic test_back_to_back();
        int acks;
        logic [5:0] pat;
        @(posedge clk); #1;
        bus.wb_adr_i = 32'h7004_000C; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
        bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat[i] = bus.wb_ack_o;
            if (bus.wb_ack_o === 1'b1) acks++;
        end
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (pat !== 6'b010101 || acks != 3) begin
            n_bad++; $display("FAIL b2b_ack pattern=%b want=010101", pat);
        end
    endtask

    task automatic test_hex_scan();
        logic [31:0] s1, s2;
        logic [6:0] exp_seg[4];
        exp_seg[0] = 7'h00; exp_seg[1] = 7'h40; exp_seg[2] = 7'h0E; exp_seg[3] = 7'h79;
        wb_write(32'h7004_0004, 32'h0000_1F08, 4'hF);
        wb_write(32'h7004_0000, 32'h0000_0001, 4'hF);
        repeat (2) @(posedge clk);
        scan_frame();
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (cnt[d] != 150 || segv[d] !== exp_seg[d] || dpv[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL hex_digit%0d cnt=%0d seg=%h dp=%b want 150/%h/1", d, cnt[d], segv[d], dpv[d], exp_seg[d]);
            end
        end
        n_cmp++;
        if (incons != 0 || dark_bad != 0 || bad_an != 0) begin
            n_bad++; $display("FAIL hex_clean incons=%0d dark=%0d an=%0d want 0", incons, dark_bad, bad_an);
        end
        // sample points exactly 640 cycles apart
        wb_read(32'h7004_0010, s1);
        repeat (637) @(posedge clk);
        wb_read(32'h7004_0010, s2);
        n_cmp++;
        if (s2[8] !== ~s1[8] || s2[1:0] !== s1[1:0]) begin
            n_bad++; $display("FAIL frame_toggle s1=%h s2=%h want bit8 flipped, digit equal", s1, s2);
        end
    endtask

    task automatic test_brightness();
        int want[3];
        logic [3:0] lvl[3];
        lvl[0] = 4'd3; lvl[1] = 4'd15; lvl[2] = 4'd0;
        want[0] = 40; want[1] = 150; want[2] = 10;
        for (int k = 0; k < 3; k++) begin
            wb_write(32'h7004_000C, {28'd0, lvl[k]}, 4'h1);
            repeat (2) @(posedge clk);
            scan_frame();
            n_cmp++;
            if (cnt[0] != want[k] || cnt[1] != want[k] || cnt[2] != want[k] || cnt[3] != want[k]) begin
                n_bad++;
                $display("FAIL bright_%0d got=%0d/%0d/%0d/%0d want=%0d", lvl[k], cnt[0], cnt[1], cnt[2], cnt[3], want[k]);
            end
        end
        wb_write(32'h7004_000C, 32'hF, 4'h1);
    endtask

    task automatic test_raw_blank();
        wb_write(32'h7004_0008, 32'h0000_0080, 4'hF);
        wb_write(32'h7004_0000, 32'h0000_0F43, 4'hF);
        repeat (2) @(posedge clk);
        scan_frame();
        n_cmp++;
        if (cnt[2] != 0) begin n_bad++; $display("FAIL blank_d2 lit_cycles=%0d want=0", cnt[2]); end
        n_cmp++;
        if (cnt[1] != 150 || segv[1] !== 7'h7E || dpv[1] !== 1'b0) begin
            n_bad++; $display("FAIL raw_d1 cnt=%0d seg=%h dp=%b want 150/7E/0", cnt[1], segv[1], dpv[1]);
        end
        n_cmp++;
        if (segv[0] !== 7'h7F || dpv[0] !== 1'b0 || cnt[3] != 150 || dpv[3] !== 1'b0) begin
            n_bad++; $display("FAIL raw_d0d3 seg0=%h dp0=%b cnt3=%0d dp3=%b want 7F/0/150/0", segv[0], dpv[0], cnt[3], dpv[3]);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] r;
        wb_write(32'h7004_0004, 32'h0000_1234, 4'hF);
        wb_write(32'h7004_0004, 32'hFFFF_FFFF, 4'h1);
        wb_read(32'h7004_0004, r);
        n_cmp++;
        if (r !== 32'h0000_12FF) begin n_bad++; $display("FAIL sel_lane0 got=%h want=000012FF", r); end
        wb_write(32'h7004_0010, 32'hFFFF_FFFF, 4'hF);
        wb_write(32'h7004_0014, 32'hFFFF_FFFF, 4'hF);
        wb_read(32'h7004_0004, r);
        n_cmp++;
        if (r !== 32'h0000_12FF) begin n_bad++; $display("FAIL status_wr_value got=%h want=000012FF", r); end
        wb_write(32'h7004_0000, 32'hFFFF_FFFF, 4'hF);
        wb_read(32'h7004_0000, r);
        n_cmp++;
        if (r !== 32'h0000_0FF3) begin n_bad++; $display("FAIL ctrl_reserved got=%h want=00000FF3", r); end
        wb_write(32'h7004_0000, 32'hFFFF_FFFF, 4'h2);
        wb_write(32'h7004_0000, 32'h0000_0000, 4'h1);
        wb_read(32'h7004_0000, r);
        n_cmp++;
        if (r !== 32'h0000_0F00) begin n_bad++; $display("FAIL ctrl_lane0 got=%h want=00000F00", r); end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] r;
        int n;
        wb_write(32'h7004_0000, 32'h0000_0001, 4'hF);
        n = 0;
        while (an !== 4'hB && n < 1000) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (an !== 4'hB) begin n_bad++; $display("FAIL wait_anB got=%h want=B", an); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_bad++; $display("FAIL midreset_pins an=%h seg=%h dp=%b want F/7F/1", an, seg, dp);
        end
        reset = 1'b0;
        wb_read(32'h7004_0010, r);
        n_cmp++;
        if (r[1:0] !== 2'd0 || r[8] !== 1'b0) begin n_bad++; $display("FAIL midreset_status got=%h want=0", r); end
        wb_read(32'h7004_0000, r);
        n_cmp++;
        if (r !== 32'h0) begin n_bad++; $display("FAIL midreset_ctrl got=%h want=0", r); end
        scan_frame();
        n_cmp++;
        if (cnt[0] + cnt[1] + cnt[2] + cnt[3] != 0 || dark_bad != 0 || bad_an != 0) begin
            n_bad++; $display("FAIL midreset_dark lit=%0d want=0", cnt[0] + cnt[1] + cnt[2] + cnt[3]);
        end
    endtask

    initial begin
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset_pins_then_release();
        test_back_to_back();
        test_hex_scan();
        test_brightness();
        test_raw_blank();
        test_byte_lanes();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic test_reset_pins_then_release();
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_bad++; $display("FAIL inreset_pins an=%h seg=%h dp=%b want F/7F/1", an, seg, dp);
        end
        reset = 1'b0;
        test_reset();
    endtask

    // hard stop in case a wait escapes its bound
    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
